// File: rtl/axi_burst_frame_writer.sv
// AXI4 write master that fills a frame buffer with fixed-length INCR bursts.
// Each beat carries a test pattern: a colour bar, a running beat count, or the beat's own byte address.
module axi_burst_frame_writer #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 64,
  parameter int                BURST_LEN   = 16,
  parameter logic [ADDR_W-1:0] ADDR_START  = ADDR_W'(32'h1000_0000),
  parameter int                FRAME_BYTES = 8294400
) (
  input  logic                aclk,
  input  logic                aresetn,

  input  logic                start,
  input  logic                stop,
  input  logic [1:0]          mode,
  output logic                busy,
  output logic                frame_done,
  output logic [15:0]         err_cnt,
  output logic [1:0]          last_bresp,

  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [3:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic [2:0]          m_axi_awprot,
  output logic [3:0]          m_axi_awcache,
  output logic                m_axi_awlock,
  output logic [3:0]          m_axi_awqos,
  output logic [3:0]          m_axi_awregion,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,

  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,

  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready
);

  localparam int BEAT_BYTES  = DATA_W / 8;
  localparam int BEAT_SHIFT  = $clog2(BEAT_BYTES);
  localparam int BURST_BYTES = BURST_LEN * BEAT_BYTES;
  localparam int LANES       = DATA_W / 32;

  localparam logic [ADDR_W-1:0] BURST_INC = ADDR_W'(BURST_BYTES);
  localparam logic [ADDR_W-1:0] FRAME_END = ADDR_START + ADDR_W'(FRAME_BYTES);
  localparam logic [3:0]        LAST_BEAT = 4'(BURST_LEN - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [3:0]        r_beat;
  logic [31:0]       r_beat_total;
  logic [2:0]        r_colour;
  logic [1:0]        r_mode;
  logic              r_stop_pend;
  logic              r_frame_done;
  logic [15:0]       r_err_cnt;
  logic [1:0]        r_last_bresp;

  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_b_hs;
  logic              w_last_beat;
  logic              w_continue;
  logic [ADDR_W-1:0] w_next_addr;
  logic              w_wrap;
  logic [ADDR_W-1:0] w_beat_addr;
  logic [31:0]       w_pixel;
  logic [31:0]       w_lane;

  function automatic logic [23:0] colour_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    colour_rgb = 24'hFF0000;
      3'd1:    colour_rgb = 24'h00FF00;
      3'd2:    colour_rgb = 24'h0000FF;
      3'd3:    colour_rgb = 24'hFFFF00;
      3'd4:    colour_rgb = 24'hFF00FF;
      3'd5:    colour_rgb = 24'h00FFFF;
      default: colour_rgb = 24'hFFFFFF;
    endcase
  endfunction

  assign w_aw_hs     = (r_state == S_ADDR) && m_axi_awready;
  assign w_w_hs      = (r_state == S_DATA) && m_axi_wready;
  assign w_b_hs      = (r_state == S_RESP) && m_axi_bvalid;
  assign w_last_beat = (r_beat == LAST_BEAT);
  // A stop arriving in the same cycle as the decision counts as already pending.
  assign w_continue  = start && !r_stop_pend && !stop;
  assign w_next_addr = r_cur_addr + BURST_INC;
  assign w_wrap      = (w_next_addr == FRAME_END);
  assign w_beat_addr = r_cur_addr + (ADDR_W'(r_beat) << BEAT_SHIFT);

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_continue)                w_next_state = S_ADDR;
      S_ADDR: if (m_axi_awready)             w_next_state = S_DATA;
      S_DATA: if (w_w_hs && w_last_beat)     w_next_state = S_RESP;
      S_RESP: if (m_axi_bvalid)              w_next_state = w_continue ? S_ADDR : S_IDLE;
      default:                               w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= S_IDLE;
      r_stop_pend <= 1'b0;
      r_mode      <= 2'd0;
    end else begin
      r_state <= w_next_state;
      if (w_b_hs || (r_state == S_IDLE)) begin
        r_stop_pend <= 1'b0;
      end else if (stop) begin
        r_stop_pend <= 1'b1;
      end
      if ((r_state == S_IDLE) && w_continue) begin
        r_mode <= mode;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_beat       <= 4'd0;
      r_beat_total <= 32'd0;
    end else if (w_w_hs) begin
      r_beat       <= w_last_beat ? 4'd0 : r_beat + 4'd1;
      r_beat_total <= r_beat_total + 32'd1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cur_addr   <= ADDR_START;
      r_colour     <= 3'd0;
      r_frame_done <= 1'b0;
      r_err_cnt    <= 16'd0;
      r_last_bresp <= 2'b00;
    end else begin
      r_frame_done <= w_b_hs && w_wrap;
      if (w_b_hs) begin
        r_last_bresp <= m_axi_bresp;
        if ((m_axi_bresp != 2'b00) && (r_err_cnt != 16'hFFFF)) begin
          r_err_cnt <= r_err_cnt + 16'd1;
        end
        if (w_wrap) begin
          r_cur_addr <= ADDR_START;
          r_colour   <= (r_colour == 3'd6) ? 3'd0 : r_colour + 3'd1;
        end else begin
          r_cur_addr <= w_next_addr;
        end
      end
    end
  end

  // Pattern sources only change on handshakes, so wdata holds steady through W stalls.
  assign w_pixel = {8'h00, colour_rgb(r_colour)};

  always_comb begin
    w_lane = w_pixel;
    case (r_mode)
      2'd1:    w_lane = r_beat_total;
      2'd2:    w_lane = 32'(w_beat_addr);
      default: w_lane = w_pixel;
    endcase
  end

  assign m_axi_wdata    = {LANES{w_lane}};
  assign m_axi_wstrb    = '1;
  assign m_axi_wlast    = (r_state == S_DATA) && w_last_beat;
  assign m_axi_wvalid   = (r_state == S_DATA);

  assign m_axi_awaddr   = r_cur_addr;
  assign m_axi_awlen    = LAST_BEAT;
  assign m_axi_awsize   = 3'(BEAT_SHIFT);
  assign m_axi_awburst  = 2'b01;
  assign m_axi_awprot   = 3'b000;
  assign m_axi_awcache  = 4'b0011;
  assign m_axi_awlock   = 1'b0;
  assign m_axi_awqos    = 4'd0;
  assign m_axi_awregion = 4'd0;
  assign m_axi_awvalid  = (r_state == S_ADDR);

  assign m_axi_bready   = (r_state == S_RESP);

  assign busy       = (r_state != S_IDLE);
  assign frame_done = r_frame_done;
  assign err_cnt    = r_err_cnt;
  assign last_bresp = r_last_bresp;

endmodule

// File: tb/tb_axi_burst_frame_writer.sv
// Directed bench: a default-size writer and a 256-byte-frame writer share the slave-side stimulus;
// a negedge monitor on the selected one records handshakes and checks stall stability.
module tb_axi_burst_frame_writer;

  logic        aclk;
  logic        aresetn;
  logic        start;
  logic        start_s;
  logic        stop;
  logic [1:0]  mode;
  logic        awready;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        sel;

  logic        d_busy, d_fd, d_awlock, d_awvalid, d_wlast, d_wvalid, d_bready;
  logic [15:0] d_err_cnt;
  logic [1:0]  d_last_bresp, d_awburst;
  logic [31:0] d_awaddr;
  logic [3:0]  d_awlen, d_awcache, d_awqos, d_awregion;
  logic [2:0]  d_awsize, d_awprot;
  logic [63:0] d_wdata;
  logic [7:0]  d_wstrb;

  logic        s_busy, s_fd, s_awlock, s_awvalid, s_wlast, s_wvalid, s_bready;
  logic [15:0] s_err_cnt;
  logic [1:0]  s_last_bresp, s_awburst;
  logic [31:0] s_awaddr;
  logic [3:0]  s_awlen, s_awcache, s_awqos, s_awregion;
  logic [2:0]  s_awsize, s_awprot;
  logic [63:0] s_wdata;
  logic [7:0]  s_wstrb;

  axi_burst_frame_writer u_dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .stop(stop), .mode(mode),
    .busy(d_busy), .frame_done(d_fd), .err_cnt(d_err_cnt), .last_bresp(d_last_bresp),
    .m_axi_awaddr(d_awaddr), .m_axi_awlen(d_awlen), .m_axi_awsize(d_awsize),
    .m_axi_awburst(d_awburst), .m_axi_awprot(d_awprot), .m_axi_awcache(d_awcache),
    .m_axi_awlock(d_awlock), .m_axi_awqos(d_awqos), .m_axi_awregion(d_awregion),
    .m_axi_awvalid(d_awvalid), .m_axi_awready(awready),
    .m_axi_wdata(d_wdata), .m_axi_wstrb(d_wstrb), .m_axi_wlast(d_wlast),
    .m_axi_wvalid(d_wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(d_bready)
  );

  axi_burst_frame_writer #(.FRAME_BYTES(256)) u_dut_small (
    .aclk(aclk), .aresetn(aresetn), .start(start_s), .stop(stop), .mode(mode),
    .busy(s_busy), .frame_done(s_fd), .err_cnt(s_err_cnt), .last_bresp(s_last_bresp),
    .m_axi_awaddr(s_awaddr), .m_axi_awlen(s_awlen), .m_axi_awsize(s_awsize),
    .m_axi_awburst(s_awburst), .m_axi_awprot(s_awprot), .m_axi_awcache(s_awcache),
    .m_axi_awlock(s_awlock), .m_axi_awqos(s_awqos), .m_axi_awregion(s_awregion),
    .m_axi_awvalid(s_awvalid), .m_axi_awready(awready),
    .m_axi_wdata(s_wdata), .m_axi_wstrb(s_wstrb), .m_axi_wlast(s_wlast),
    .m_axi_wvalid(s_wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(s_bready)
  );

  logic        mon_awvalid, mon_wvalid, mon_wlast, mon_bready, mon_fd, mon_busy;
  logic [31:0] mon_awaddr;
  logic [63:0] mon_wdata;

  assign mon_awvalid = sel ? s_awvalid : d_awvalid;
  assign mon_awaddr  = sel ? s_awaddr  : d_awaddr;
  assign mon_wvalid  = sel ? s_wvalid  : d_wvalid;
  assign mon_wdata   = sel ? s_wdata   : d_wdata;
  assign mon_wlast   = sel ? s_wlast   : d_wlast;
  assign mon_bready  = sel ? s_bready  : d_bready;
  assign mon_fd      = sel ? s_fd      : d_fd;
  assign mon_busy    = sel ? s_busy    : d_busy;

  localparam logic [63:0] RED   = 64'h00FF0000_00FF0000;
  localparam logic [63:0] GREEN = 64'h0000FF00_0000FF00;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [31:0] aw_q[$];
  logic [63:0] w_q[$];
  logic        wl_q[$];
  int          b_cnt  = 0;
  int          fd_cnt = 0;
  logic        pa_stall = 1'b0;
  logic        pw_stall = 1'b0;
  logic [31:0] pa_addr;
  logic [63:0] pw_data;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_log();
    aw_q.delete();
    w_q.delete();
    wl_q.delete();
    b_cnt  = 0;
    fd_cnt = 0;
  endtask

  task automatic do_reset();
    start   = 1'b0;
    start_s = 1'b0;
    stop    = 1'b0;
    aresetn = 1'b0;
    step();
    step();
    aresetn = 1'b1;
    clear_log();
  endtask

  task automatic wait_idle(input string tag);
    for (int c = 0; c < 200 && mon_busy; c++) step();
    check(tag, mon_busy, 1'b0);
  endtask

  // Handshakes are recorded half a cycle before the edge that completes them.
  always @(negedge aclk) begin
    if (!aresetn) begin
      pa_stall = 1'b0;
      pw_stall = 1'b0;
    end else begin
      if (pa_stall) check("aw_hold", {mon_awvalid, mon_awaddr}, {1'b1, pa_addr});
      if (pw_stall) check("w_hold", {mon_wvalid, mon_wdata[62:0]}, {1'b1, pw_data[62:0]});
      if (mon_awvalid && awready) aw_q.push_back(mon_awaddr);
      if (mon_wvalid && wready) begin
        w_q.push_back(mon_wdata);
        wl_q.push_back(mon_wlast);
      end
      if (mon_bready && bvalid) b_cnt++;
      if (mon_fd) fd_cnt++;
      pa_stall = mon_awvalid && !awready;
      pa_addr  = mon_awaddr;
      pw_stall = mon_wvalid && !wready;
      pw_data  = mon_wdata;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sel = 1'b0; start = 1'b0; start_s = 1'b0; stop = 1'b0; mode = 2'd0;
    awready = 1'b1; wready = 1'b1; bresp = 2'b00; bvalid = 1'b1;
    aresetn = 1'b1;
    #2 aresetn = 1'b0;
    #1;
    // Reset state and constant AW fields
    check("rst_valids", {d_awvalid, d_wvalid, d_wlast, d_bready, d_busy, d_fd}, 6'b0);
    check("rst_err_cnt", d_err_cnt, 16'd0);
    check("rst_last_bresp", d_last_bresp, 2'b00);
    check("rst_awaddr", d_awaddr, 32'h1000_0000);
    check("awlen", d_awlen, 4'hF);
    check("awsize", d_awsize, 3'd3);
    check("awburst", d_awburst, 2'b01);
    check("awcache_prot", {d_awcache, d_awprot, d_awlock, d_awqos, d_awregion}, {4'b0011, 3'b000, 1'b0, 8'h00});
    check("wstrb", d_wstrb, 8'hFF);
    step();
    aresetn = 1'b1;
    clear_log();

    // Three back-to-back bursts with an always-ready slave
    start = 1'b1;
    for (int c = 0; c < 2000 && aw_q.size() < 3; c++) step();
    start = 1'b0;
    wait_idle("t1_idle");
    check("t1_aw_count", aw_q.size(), 3);
    check("t1_w_count", w_q.size(), 48);
    check("t1_b_count", b_cnt, 3);
    check("t1_awaddr0", aw_q[0], 32'h1000_0000);
    check("t1_awaddr1", aw_q[1], 32'h1000_0080);
    check("t1_awaddr2", aw_q[2], 32'h1000_0100);
    for (int i = 0; i < w_q.size(); i++) begin
      check($sformatf("t1_wdata[%0d]", i), w_q[i], RED);
      check($sformatf("t1_wlast[%0d]", i), wl_q[i], (i % 16) == 15);
    end

    // AW held off for 5 cycles, W ready randomly toggled
    do_reset();
    start = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      awready = (c >= 5);
      wready  = 1'($urandom_range(0, 1));
      if (b_cnt >= 2) start = 1'b0;
      if (b_cnt >= 2 && !d_busy) break;
      step();
    end
    awready = 1'b1;
    wready  = 1'b1;
    wait_idle("t2_idle");
    check("t2_aw_ge2", aw_q.size() >= 2, 1'b1);
    check("t2_w_count", w_q.size(), 16 * aw_q.size());
    check("t2_b_count", b_cnt, aw_q.size());
    check("t2_awaddr0", aw_q[0], 32'h1000_0000);
    check("t2_awaddr1", aw_q[1], 32'h1000_0080);
    for (int i = 0; i < w_q.size(); i++) begin
      check($sformatf("t2_wdata[%0d]", i), w_q[i], RED);
      check($sformatf("t2_wlast[%0d]", i), wl_q[i], (i % 16) == 15);
    end

    // Mode 2 (beat address) then mode 1 (running beat count)
    do_reset();
    mode  = 2'd2;
    start = 1'b1;
    for (int c = 0; c < 200 && aw_q.size() < 1; c++) step();
    start = 1'b0;
    mode  = 2'd1;
    wait_idle("t3_idle_m2");
    start = 1'b1;
    for (int c = 0; c < 200 && aw_q.size() < 2; c++) step();
    start = 1'b0;
    mode  = 2'd0;
    wait_idle("t3_idle_m1");
    check("t3_w_count", w_q.size(), 32);
    check("t3_awaddr1", aw_q[1], 32'h1000_0080);
    for (int i = 0; i < 16; i++) begin
      logic [31:0] a;
      logic [31:0] n;
      a = 32'h1000_0000 + 32'(i * 8);
      n = 32'(16 + i);
      check($sformatf("t3_mode2[%0d]", i), w_q[i], {a, a});
      check($sformatf("t3_mode1[%0d]", i), w_q[16 + i], {n, n});
    end

    // Error responses on three bursts, then OKAY
    do_reset();
    start = 1'b1;
    for (int c = 0; c < 2000 && b_cnt < 3; c++) begin
      bresp = (b_cnt < 3) ? 2'b10 : 2'b00;
      step();
    end
    bresp = 2'b00;
    check("t5_err_cnt3", d_err_cnt, 16'd3);
    check("t5_bresp_slverr", d_last_bresp, 2'b10);
    for (int c = 0; c < 200 && b_cnt < 4; c++) step();
    start = 1'b0;
    check("t5_b4_seen", b_cnt >= 4, 1'b1);
    wait_idle("t5_idle");
    check("t5_err_cnt_hold", d_err_cnt, 16'd3);
    check("t5_bresp_okay", d_last_bresp, 2'b00);

    // Stop pulse during beat 4 with start held high
    do_reset();
    start = 1'b1;
    for (int c = 0; c < 200 && w_q.size() < 4; c++) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int c = 0; c < 200 && b_cnt < 1; c++) step();
    check("t6_b_done", b_cnt, 1);
    check("t6_idle_after_b", {d_busy, d_awvalid}, 2'b00);
    start = 1'b0;
    repeat (10) step();
    check("t6_aw_count", aw_q.size(), 1);
    check("t6_w_count", w_q.size(), 16);
    check("t6_wlast", wl_q[15], 1'b1);
    check("t6_busy", d_busy, 1'b0);

    // Reset during beat 7
    do_reset();
    start = 1'b1;
    for (int c = 0; c < 200 && w_q.size() < 7; c++) step();
    check("t7_mid_data", d_wvalid, 1'b1);
    aresetn = 1'b0;
    #1;
    check("t7_async_clear", {d_awvalid, d_wvalid, d_wlast, d_bready, d_busy}, 5'b0);
    start = 1'b0;
    step();
    aresetn = 1'b1;
    clear_log();
    repeat (5) step();
    check("t7_no_aw_before_start", aw_q.size(), 0);
    check("t7_idle", d_busy, 1'b0);
    start = 1'b1;
    for (int c = 0; c < 200 && aw_q.size() < 1; c++) step();
    start = 1'b0;
    check("t7_first_awaddr", aw_q[0], 32'h1000_0000);
    wait_idle("t7_idle_end");

    // 256-byte frame: wrap after the second burst, colour advances
    sel = 1'b1;
    do_reset();
    start_s = 1'b1;
    for (int c = 0; c < 2000 && aw_q.size() < 3; c++) step();
    start_s = 1'b0;
    wait_idle("t4_idle");
    check("t4_aw_count", aw_q.size(), 3);
    check("t4_awaddr0", aw_q[0], 32'h1000_0000);
    check("t4_awaddr1", aw_q[1], 32'h1000_0080);
    check("t4_awaddr2_wrap", aw_q[2], 32'h1000_0000);
    check("t4_frame_done_once", fd_cnt, 1);
    check("t4_cur_addr", s_awaddr, 32'h1000_0080);
    check("t4_w_count", w_q.size(), 48);
    for (int i = 0; i < w_q.size(); i++) begin
      check($sformatf("t4_wdata[%0d]", i), w_q[i], (i < 32) ? RED : GREEN);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axi_burst_frame_writer.md
AXI_BURST_FRAME_WRITER -- requirements
Module: axi_burst_frame_writer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 64, data width; legal values 32, 64, 128.
REQ-003 SHALL have parameter BURST_LEN, default 16, beats per burst; legal values 1..16.
REQ-004 SHALL have parameter ADDR_START, default 32'h10000000, frame base; aligned to BURST_BYTES = BURST_LEN*DATA_W/8.
REQ-005 SHALL have parameter FRAME_BYTES, default 8294400, frame size in bytes; a nonzero multiple of BURST_BYTES.
REQ-006 SHALL have ports aclk in 1 (clock) and aresetn in 1 (one clock; asynchronous, active-low reset).
REQ-007 SHALL have ports start in 1 (level enable), stop in 1 (pulse), mode in 2 (pattern select).
REQ-008 SHALL have ports busy out 1, frame_done out 1 (pulse), err_cnt out 16, last_bresp out 2.
REQ-009 SHALL have AW ports: m_axi_awaddr out ADDR_W, m_axi_awlen out 4, m_axi_awsize out 3, m_axi_awburst out 2, m_axi_awvalid out 1, m_axi_awready in 1.
REQ-010 SHALL have W ports: m_axi_wdata out DATA_W, m_axi_wstrb out DATA_W/8, m_axi_wlast out 1, m_axi_wvalid out 1, m_axi_wready in 1.
REQ-011 SHALL have B ports: m_axi_bresp in 2, m_axi_bvalid in 1, m_axi_bready out 1.
REQ-012 SHALL drive constants: awprot 3'b000, awcache 4'b0011, awlock 0, awqos 0, awregion 0, awburst 2'b01, awsize $clog2(DATA_W/8), awlen BURST_LEN-1, wstrb all ones.

Function
REQ-013 SHALL implement FSM IDLE, ADDR, DATA, RESP; IDLE->ADDR when start=1 and stop not pending.
REQ-014 In ADDR, SHALL assert awvalid with awaddr=cur_addr held stable until awready; on handshake go to DATA.
REQ-015 SHALL never deassert awvalid or wvalid before the handshake completes.
REQ-016 In DATA, SHALL assert wvalid; beat counter increments only on wvalid&&wready.
REQ-017 SHALL assert wlast when beat counter equals BURST_LEN-1; on that handshake go to RESP.
REQ-018 SHALL hold wdata stable while wvalid=1 and wready=0.
REQ-019 In RESP, SHALL assert bready; on bvalid capture bresp into last_bresp.
REQ-020 On B handshake with bresp!=2'b00, SHALL increment err_cnt, saturating at 16'hFFFF.
REQ-021 On B handshake, SHALL advance cur_addr by BURST_BYTES; if the result equals ADDR_START+FRAME_BYTES, load ADDR_START, pulse frame_done for one cycle, increment colour index modulo 7.
REQ-022 After the B handshake, SHALL go to ADDR if start=1 and no stop pending, else IDLE.
REQ-023 stop SHALL be latched; the current burst completes fully (AW, all W beats, B); then IDLE and the latch clears.
REQ-024 SHALL sample mode only in IDLE->ADDR; mode is constant for the burst.
REQ-025 Pixel is 32 bits {8'h00,R,G,B}; wdata is the pixel replicated DATA_W/32 times for mode 0.
REQ-026 Mode 0 colour sequence by index 0..6: FF0000, 00FF00, 0000FF, FFFF00, FF00FF, 00FFFF, FFFFFF.
REQ-027 Mode 1: each 32-bit lane = running beat count since reset, counting every W handshake and wrapping at 2^32.
REQ-028 Mode 2: each 32-bit lane = low 32 bits of the byte address of that beat; mode 3 behaves as mode 0.
REQ-029 busy SHALL be 1 whenever the state is not IDLE.
REQ-030 If start drops mid-burst without stop, the burst SHALL complete and FSM returns to IDLE.

Reset
REQ-031 aresetn=0 SHALL asynchronously force IDLE, awvalid=wvalid=wlast=bready=0, busy=0, frame_done=0, err_cnt=0, last_bresp=0, cur_addr=ADDR_START, colour index 0, beat counts 0, stop latch 0.
REQ-032 Reset mid-burst SHALL abandon the transaction with no further valid assertions until start.

Verification
REQ-033 Defaults, start=1, awready=wready=bvalid=1, bresp=0 -> awaddr 10000000, 10000080, 10000100; 16 beats each; wlast on beat 15; wdata 00FF000000FF0000.
REQ-034 awready low 5 cycles, wready toggled randomly -> awaddr/awvalid stable; wdata stable while stalled; exactly 16 W handshakes per burst.
REQ-035 FRAME_BYTES=256, mode 0 -> after second B handshake frame_done pulses once, awaddr returns to 10000000, wdata 0000FF0000 00FF00 pattern (index 1).
REQ-036 bresp=2'b10 on 3 bursts -> err_cnt=3, last_bresp=2'b10; next OKAY -> err_cnt=3, last_bresp=0.
REQ-037 stop pulse during beat 4 -> burst finishes with wlast and B handshake, then IDLE, busy=0, no further awvalid.
REQ-038 aresetn low during DATA beat 7 -> all valids 0 immediately; after release and start, first awaddr=10000000.
